// File: rtl/tree_pkg.sv
// tree_pkg: shared defaults and tree sizing helper for pipelined_max_tree
package tree_pkg;
  localparam int DEF_N_VALUES = 8;
  localparam int DEF_VALUE_WIDTH = 32;
  function automatic int tree_levels(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tree_node.sv
// tree_node: combinational two-way max select; the left (lower-index) child wins ties
module tree_node
  import tree_pkg::*;
#(
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int IDX_WIDTH = 3
) (
  input  logic                   a_any,
  input  logic [IDX_WIDTH-1:0]   a_idx,
  input  logic [VALUE_WIDTH-1:0] a_value,
  input  logic                   b_any,
  input  logic [IDX_WIDTH-1:0]   b_idx,
  input  logic [VALUE_WIDTH-1:0] b_value,
  output logic                   y_any,
  output logic [IDX_WIDTH-1:0]   y_idx,
  output logic [VALUE_WIDTH-1:0] y_value
);
  logic pick_b;
  // right child wins only when it is the sole candidate or strictly larger
  always_comb begin
    pick_b = b_any && (!a_any || (b_value > a_value));
    y_any = a_any || b_any;
    y_idx = !y_any ? '0 : pick_b ? b_idx : a_idx;
    y_value = !y_any ? '0 : pick_b ? b_value : a_value;
  end
endmodule

// File: rtl/pipelined_max_tree.sv
// pipelined_max_tree: registered argmax tree with rigid valid/ready pipeline; optional TREE_THRESHOLD_EN adds a leaf threshold port
module pipelined_max_tree
  import tree_pkg::*;
#(
  parameter int N_VALUES = DEF_N_VALUES,
  parameter int VALUE_WIDTH = DEF_VALUE_WIDTH,
  localparam int IDX_WIDTH = $clog2(N_VALUES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [VALUE_WIDTH-1:0] values [N_VALUES],
  input  logic [N_VALUES-1:0]    enable,
`ifdef TREE_THRESHOLD_EN
  input  logic [VALUE_WIDTH-1:0] threshold,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_any,
  output logic [IDX_WIDTH-1:0]   out_idx,
  output logic [VALUE_WIDTH-1:0] out_value
);
  localparam int LEVELS = tree_levels(N_VALUES);
  localparam int PAD = 1 << LEVELS;
  typedef struct packed {
    logic                   any;
    logic [IDX_WIDTH-1:0]   idx;
    logic [VALUE_WIDTH-1:0] value;
  } node_t;
  node_t leaf [PAD];
  node_t nxt [1:PAD-1];
  node_t q [1:PAD-1];
  logic [LEVELS-1:0] vld;
  logic adv;
  assign adv = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign out_valid = vld[LEVELS-1];
  assign out_any = q[1].any;
  assign out_idx = q[1].idx;
  assign out_value = q[1].value;
  for (genvar i = 0; i < PAD; i++) begin : g_leaf
    if (i < N_VALUES) begin : g_real
      logic en;
`ifdef TREE_THRESHOLD_EN
      assign en = in_valid && enable[i] && (values[i] > threshold);
`else
      assign en = in_valid && enable[i];
`endif
      assign leaf[i] = en ? node_t'{1'b1, IDX_WIDTH'(i), values[i]} : '0;
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end
  for (genvar k = 1; k < PAD; k++) begin : g_node
    node_t a, b;
    logic y_any;
    logic [IDX_WIDTH-1:0] y_idx;
    logic [VALUE_WIDTH-1:0] y_value;
    if (2 * k >= PAD) begin : g_leaf_kids
      assign a = leaf[2*k-PAD];
      assign b = leaf[2*k+1-PAD];
    end else begin : g_reg_kids
      assign a = q[2*k];
      assign b = q[2*k+1];
    end
    tree_node #(.VALUE_WIDTH(VALUE_WIDTH), .IDX_WIDTH(IDX_WIDTH)) u_node (
      .a_any(a.any), .a_idx(a.idx), .a_value(a.value),
      .b_any(b.any), .b_idx(b.idx), .b_value(b.value),
      .y_any(y_any), .y_idx(y_idx), .y_value(y_value)
    );
    assign nxt[k] = node_t'{y_any, y_idx, y_value};
  end
  // every stage advances together unless the output is stalled
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
      for (int k = 1; k < PAD; k++) q[k] <= '0;
    end else if (adv) begin
      vld <= LEVELS'({vld, in_valid});
      q <= nxt;
    end
  end
endmodule
